div_out_monitor: RTL and testbench

- Downstream checker that consumes the output of the divide-by-N stages (div-by-9, div-by-12, div-by-80), sampled in the source `clk` domain.
- Measures each period and high time of the divided signal in `clk` cycles.
- Flags period and duty-cycle errors and stalls; declares lock after a run of good periods.
- Used in the divider testbenches and as an on-chip health monitor.

---
 rtl/div_out_monitor_if.sv | 23 ++
 rtl/div_out_monitor.sv | 145 ++++++++++++++
 tb/tb_div_out_monitor.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div_out_monitor_if.sv
// rtl/div_out_monitor_if.sv - divided-clock input and measurement outputs of div_out_monitor
interface div_out_monitor_if #(
    parameter int CNT_W = 8
);
    logic             div_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             period_err;
    logic             duty_err;
    logic             stall;
    logic             locked;

    modport master (
        output div_in,
        input  period_out, high_out, meas_valid, period_err, duty_err, stall, locked
    );

    modport slave (
        input  div_in,
        output period_out, high_out, meas_valid, period_err, duty_err, stall, locked
    );
endinterface

// File: rtl/div_out_monitor.sv
// rtl/div_out_monitor.sv - period/duty/stall/lock monitor for a divided clock; DIV_MON_SYNC_EN adds a 2-flop input synchronizer
module div_out_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 9,
    parameter int DUTY_TOL   = 1,
    parameter int LOCK_CNT   = 4,
    parameter int STALL_CNT  = 36
) (
    input  logic clk,
    input  logic reset,
    div_out_monitor_if.slave mon
);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  EXP_P   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W+1:0]  TOL_U   = (CNT_W+2)'(DUTY_TOL);
    localparam logic [31:0]       STALL_U = 32'(STALL_CNT);
    localparam logic [GOOD_W-1:0] LOCK_G  = GOOD_W'(LOCK_CNT);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t            state, state_nxt;
    logic              samp_in;
    logic              s1, s2, rise;
    logic [CNT_W-1:0]  period_cnt, high_cnt;
    logic              period_sat;
    logic [GOOD_W-1:0] good_cnt, good_inc;
    logic              stall_hit, meas_evt, stall_evt;
    logic              period_bad, duty_bad;
    logic signed [CNT_W+1:0] duty_diff;
    logic [CNT_W+1:0]  duty_abs;

    logic [CNT_W-1:0]  period_r, high_r;
    logic              meas_valid_r, period_err_r, duty_err_r, stall_r, locked_r;

`ifdef DIV_MON_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], mon.div_in};
    end
    assign samp_in = sync_q[1];
`else
    assign samp_in = mon.div_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= samp_in;
            s2 <= s1;
        end
    end
    assign rise = s1 & ~s2;

    // Counters start at 1 on the rise so the rise cycle itself is counted
    assign period_sat = (period_cnt == CNT_MAX);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
        end else begin
            if (!period_sat)             period_cnt <= period_cnt + CNT_W'(1);
            if (s1 && high_cnt != CNT_MAX) high_cnt <= high_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    assign stall_hit = !rise && (32'(period_cnt) == STALL_U);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise)      state_nxt = MEAS;
            MEAS:    if (stall_hit) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        meas_evt  = 1'b0;
        stall_evt = 1'b0;
        if (state == MEAS) begin
            meas_evt  = rise;
            stall_evt = stall_hit;
        end
    end

    // |2*high - period| in CNT_W+2 bits holds the full -max..2*max range
    assign duty_diff  = $signed({1'b0, high_cnt, 1'b0}) - $signed({2'b00, period_cnt});
    assign duty_abs   = duty_diff[CNT_W+1] ? (CNT_W+2)'(-duty_diff) : duty_diff;
    assign duty_bad   = (duty_abs > TOL_U);
    assign period_bad = (period_cnt != EXP_P) || period_sat;
    assign good_inc   = (good_cnt == LOCK_G) ? good_cnt : good_cnt + GOOD_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_r     <= '0;
            high_r       <= '0;
            meas_valid_r <= 1'b0;
            period_err_r <= 1'b0;
            duty_err_r   <= 1'b0;
            stall_r      <= 1'b0;
            locked_r     <= 1'b0;
            good_cnt     <= '0;
        end else begin
            meas_valid_r <= meas_evt;
            if (rise) stall_r <= 1'b0;
            if (meas_evt) begin
                period_r     <= period_cnt;
                high_r       <= high_cnt;
                period_err_r <= period_bad;
                duty_err_r   <= duty_bad;
                if (!period_bad && !duty_bad) begin
                    good_cnt <= good_inc;
                    if (good_inc == LOCK_G) locked_r <= 1'b1;
                end else begin
                    good_cnt <= '0;
                    locked_r <= 1'b0;
                end
            end else if (stall_evt) begin
                stall_r  <= 1'b1;
                locked_r <= 1'b0;
                good_cnt <= '0;
            end
        end
    end

    assign mon.period_out = period_r;
    assign mon.high_out   = high_r;
    assign mon.meas_valid = meas_valid_r;
    assign mon.period_err = period_err_r;
    assign mon.duty_err   = duty_err_r;
    assign mon.stall      = stall_r;
    assign mon.locked     = locked_r;
endmodule

// File: tb/tb_div_out_monitor.sv
// tb/tb_div_out_monitor.sv - directed table-driven bench for div_out_monitor
module tb_div_out_monitor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_out_monitor_if #(.CNT_W(8)) ifc ();
    div_out_monitor_if #(.CNT_W(8)) ifs ();

    div_out_monitor u_dut (.clk(clk), .reset(reset), .mon(ifc));
    div_out_monitor #(.STALL_CNT(300)) u_sat (.clk(clk), .reset(reset), .mon(ifs));

    typedef struct {
        logic [7:0] p;
        logic [7:0] h;
        logic       pe;
        logic       de;
        logic       lk;
    } meas_t;

    typedef struct {
        int hi;
        int lo;
        int p;
        int h;
        bit pe;
        bit de;
        bit lk;
    } vec_t;

    meas_t meas_q[$];
    meas_t sat_q[$];
    vec_t  vecs[16];

    always @(negedge clk) begin
        if (ifc.meas_valid)
            meas_q.push_back('{ifc.period_out, ifc.high_out, ifc.period_err, ifc.duty_err, ifc.locked});
        if (ifs.meas_valid)
            sat_q.push_back('{ifs.period_out, ifs.high_out, ifs.period_err, ifs.duty_err, ifs.locked});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int hi, input int lo);
        for (int i = 0; i < hi; i++) begin ifc.div_in = 1'b1; tick(); end
        for (int i = 0; i < lo; i++) begin ifc.div_in = 1'b0; tick(); end
    endtask

    task automatic wait_meas(input int n, input int budget, input string name);
        int k = 0;
        while (meas_q.size() < n && k < budget) begin tick(); k++; end
        chk(name, meas_q.size(), n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, ifc.period_out, 0);
        chk({tag, "_high"},   ifc.high_out, 0);
        chk({tag, "_valid"},  ifc.meas_valid, 0);
        chk({tag, "_perr"},   ifc.period_err, 0);
        chk({tag, "_derr"},   ifc.duty_err, 0);
        chk({tag, "_stall"},  ifc.stall, 0);
        chk({tag, "_locked"}, ifc.locked, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        meas_t m;

        for (int i = 0; i < 16; i++) vecs[i] = '{5, 4, 9, 5, 1'b0, 1'b0, 1'b0};
        vecs[3].lk  = 1'b1;
        vecs[4].lk  = 1'b1;
        vecs[5]     = '{6, 4, 10, 6, 1'b1, 1'b1, 1'b0};
        vecs[9].lk  = 1'b1;
        vecs[10]    = '{7, 2, 9, 7, 1'b0, 1'b1, 1'b0};
        vecs[11]    = '{7, 2, 9, 7, 1'b0, 1'b1, 1'b0};
        vecs[15].lk = 1'b1;

        ifc.div_in = 1'b0;
        ifs.div_in = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b1;
        tick();

        drive_period(vecs[0].hi, vecs[0].lo);
        chk("first_rise_discarded", meas_q.size(), 0);
        for (int i = 1; i < 16; i++) drive_period(vecs[i].hi, vecs[i].lo);
        ifc.div_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ifc.div_in = 1'b0;
        wait_meas(16, 20, "table_meas_count");
        for (int i = 0; i < 16; i++) begin
            if (i < meas_q.size()) begin
                m = meas_q[i];
                chk($sformatf("v%0d_period", i), m.p,  vecs[i].p);
                chk($sformatf("v%0d_high", i),   m.h,  vecs[i].h);
                chk($sformatf("v%0d_perr", i),   m.pe, vecs[i].pe);
                chk($sformatf("v%0d_derr", i),   m.de, vecs[i].de);
                chk($sformatf("v%0d_locked", i), m.lk, vecs[i].lk);
            end
        end

        // div_in held low: 5 high cycles already elapsed, 25 more keeps us below the 36 threshold
        for (int i = 0; i < 25; i++) tick();
        chk("stall_not_early", ifc.stall, 0);
        chk("locked_before_stall", ifc.locked, 1);
        begin
            int k = 0;
            while (!ifc.stall && k < 40) begin tick(); k++; end
        end
        chk("stall_set", ifc.stall, 1);
        chk("stall_unlocks", ifc.locked, 0);
        chk("stall_no_meas", meas_q.size(), 16);

        n0 = meas_q.size();
        drive_period(5, 4);
        chk("stall_cleared", ifc.stall, 0);
        chk("resume_first_rise_no_meas", meas_q.size(), n0);
        drive_period(5, 4);
        wait_meas(n0 + 1, 10, "resume_meas_count");
        m = meas_q[meas_q.size() - 1];
        chk("resume_period", m.p, 9);
        chk("resume_perr", m.pe, 0);
        chk("resume_locked", m.lk, 0);

        for (int i = 0; i < 5; i++) drive_period(5, 4);
        chk("relock_before_reset", ifc.locked, 1);
        ifc.div_in = 1'b1;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        ifc.div_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        n0 = meas_q.size();
        drive_period(5, 4);
        chk("post_reset_first_discarded", meas_q.size(), n0);
        drive_period(5, 4);
        wait_meas(n0 + 1, 10, "post_reset_meas_count");
        m = meas_q[meas_q.size() - 1];
        chk("post_reset_period", m.p, 9);
        chk("post_reset_high", m.h, 5);
        chk("post_reset_locked", m.lk, 0);

        ifs.div_in = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        ifs.div_in = 1'b0;
        tick();
        tick();
        chk("sat_no_stall", ifs.stall, 0);
        ifs.div_in = 1'b1;
        begin
            int k = 0;
            while (sat_q.size() < 1 && k < 10) begin tick(); k++; end
        end
        chk("sat_meas_count", sat_q.size(), 1);
        if (sat_q.size() >= 1) begin
            m = sat_q[0];
            chk("sat_period", m.p, 255);
            chk("sat_high", m.h, 255);
            chk("sat_perr", m.pe, 1);
            chk("sat_derr", m.de, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
